// File: rtl/seven_seg_scan_n_if.sv
// Pin bundle for the N-digit seven-segment scanner. There is no handshake:
// the application drives the value inputs level-style, and the scanner samples them once per frame.
interface seven_seg_scan_n_if #(
    parameter int NUM_DIGITS = 2
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              bright;

    logic [NUM_DIGITS-1:0]   dig_en_n;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_tick;

    modport master (
        output digits, dp, blank, bright,
        input  dig_en_n, seg_n, dp_n, digit_idx, frame_tick
    );

    modport slave (
        input  digits, dp, blank, bright,
        output dig_en_n, seg_n, dp_n, digit_idx, frame_tick
    );
endinterface

// File: rtl/seven_seg_scan_n.sv
// Time-multiplexed common-anode seven-segment scanner with frame-shadowed inputs,
// PWM brightness and a dead-time at the start of each digit dwell.
module seven_seg_scan_n #(
    parameter int NUM_DIGITS   = 2,
    parameter int DIV_BITS     = 16,
    parameter int BLANK_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    seven_seg_scan_n_if.slave bus
);
    localparam int                  IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_BITS-1:0] BLANK_C  = DIV_BITS'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_BITS-1:0]     cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [3:0]              sh_bright;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] eff_digits;
    logic [NUM_DIGITS-1:0]   eff_dp;
    logic [NUM_DIGITS-1:0]   eff_blank;
    logic [3:0]              eff_bright;
    logic [3:0]              nib;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   sel_n;
    logic [6:0]              seg_dec;

    assign load = (cnt == '0) && (idx == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + DIV_BITS'(1);
            if (cnt == '1) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
            sh_bright <= '0;
        end else if (load) begin
            sh_digits <= bus.digits;
            sh_dp     <= bus.dp;
            sh_blank  <= bus.blank;
            sh_bright <= bus.bright;
        end
    end

    // In the load cycle the freshly captured inputs already govern the pins.
    always_comb begin
        eff_digits = load ? bus.digits : sh_digits;
        eff_dp     = load ? bus.dp     : sh_dp;
        eff_blank  = load ? bus.blank  : sh_blank;
        eff_bright = load ? bus.bright : sh_bright;
        nib        = eff_digits[{idx, 2'b00} +: 4];
        lit        = (cnt >= BLANK_C) &&
                     (cnt[DIV_BITS-1 -: 4] <= eff_bright) &&
                     !eff_blank[idx];
        sel_n      = '1;
        if (lit) begin
            sel_n[idx] = 1'b0;
        end
    end

    always_comb begin
        seg_dec = 7'b1111111;
        case (nib)
            4'h0: seg_dec = 7'b1000000;
            4'h1: seg_dec = 7'b1111001;
            4'h2: seg_dec = 7'b0100100;
            4'h3: seg_dec = 7'b0110000;
            4'h4: seg_dec = 7'b0011001;
            4'h5: seg_dec = 7'b0010010;
            4'h6: seg_dec = 7'b0000010;
            4'h7: seg_dec = 7'b1111000;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0010000;
            4'hA: seg_dec = 7'b0001000;
            4'hB: seg_dec = 7'b0000011;
            4'hC: seg_dec = 7'b1000110;
            4'hD: seg_dec = 7'b0100001;
            4'hE: seg_dec = 7'b0000110;
            4'hF: seg_dec = 7'b0001110;
            default: seg_dec = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.dig_en_n   <= '1;
            bus.seg_n      <= '1;
            bus.dp_n       <= 1'b1;
            bus.digit_idx  <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.dig_en_n   <= sel_n;
            bus.seg_n      <= lit ? seg_dec : 7'b1111111;
            bus.dp_n       <= lit ? ~eff_dp[idx] : 1'b1;
            bus.digit_idx  <= idx;
            bus.frame_tick <= load;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Bench for seven_seg_scan_n: a 4-digit and a 3-digit instance run side by side against
// a frame-position reference model, with focused scenario checks on top.
module tb_seven_seg_scan_n;
    localparam int DWELL = 256;
    localparam int BLANK = 4;

    typedef struct packed {
        logic [7:0] dig_n;
        logic [6:0] seg_n;
        logic       dp_n;
        logic [1:0] idx;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    seven_seg_scan_n_if #(.NUM_DIGITS(4)) if4 ();
    seven_seg_scan_n_if #(.NUM_DIGITS(3)) if3 ();

    seven_seg_scan_n #(.NUM_DIGITS(4), .DIV_BITS(8), .BLANK_CYCLES(BLANK)) dut4 (
        .clk(clk), .reset(reset), .bus(if4));
    seven_seg_scan_n #(.NUM_DIGITS(3), .DIV_BITS(8), .BLANK_CYCLES(BLANK)) dut3 (
        .clk(clk), .reset(reset), .bus(if3));

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Expected pins for frame position q (cycles since the load) given the captured values.
    function automatic exp_t model_out(input int q, input logic [31:0] dg, input logic [7:0] dpv,
                                       input logic [7:0] bl, input logic [3:0] br);
        exp_t e;
        int   d;
        int   c;
        d = q / DWELL;
        c = q % DWELL;
        e.dig_n = 8'hFF;
        e.seg_n = 7'h7F;
        e.dp_n  = 1'b1;
        e.idx   = 2'(d);
        e.tick  = (q == 0);
        if (c >= BLANK && (c / 16) <= int'(br) && bl[d] == 1'b0) begin
            e.dig_n[d] = 1'b0;
            e.seg_n    = seg_tab[(dg >> (4 * d)) & 32'hF];
            e.dp_n     = ~dpv[d];
        end
        return e;
    endfunction

    int          p4, p3;
    logic [31:0] sd4, sd3;
    logic [7:0]  sdp4, sdp3, sbl4, sbl3;
    logic [3:0]  sbr4, sbr3;
    exp_t        e4, e3;
    logic [14:0] mod4;
    logic [13:0] mod3;
    logic [14:0] obs4;
    logic [13:0] obs3;

    assign obs4 = {if4.dig_en_n, if4.seg_n, if4.dp_n, if4.digit_idx, if4.frame_tick};
    assign obs3 = {if3.dig_en_n, if3.seg_n, if3.dp_n, if3.digit_idx, if3.frame_tick};

    always @(posedge clk) begin
        if (reset) begin
            p4   = 0;
            p3   = 0;
            mod4 = {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0};
            mod3 = {3'h7, 7'h7F, 1'b1, 2'd0, 1'b0};
        end else begin
            if (p4 % (4 * DWELL) == 0) begin
                sd4 = 32'(if4.digits); sdp4 = 8'(if4.dp); sbl4 = 8'(if4.blank); sbr4 = if4.bright;
            end
            e4   = model_out(p4 % (4 * DWELL), sd4, sdp4, sbl4, sbr4);
            mod4 = {e4.dig_n[3:0], e4.seg_n, e4.dp_n, e4.idx, e4.tick};
            p4++;
            if (p3 % (3 * DWELL) == 0) begin
                sd3 = 32'(if3.digits); sdp3 = 8'(if3.dp); sbl3 = 8'(if3.blank); sbr3 = if3.bright;
            end
            e3   = model_out(p3 % (3 * DWELL), sd3, sdp3, sbl3, sbr3);
            mod3 = {e3.dig_n[2:0], e3.seg_n, e3.dp_n, e3.idx, e3.tick};
            p3++;
        end
    end

    task automatic test_reset;
        reset       = 1'b1;
        if4.digits  = 16'hF821;
        if4.blank   = 4'b0000;
        if4.dp      = 4'b0100;
        if4.bright  = 4'hF;
        if3.digits  = 12'($urandom);
        if3.dp      = 3'($urandom);
        if3.blank   = 3'b000;
        if3.bright  = 4'hF;
        repeat (3) @(negedge clk);
        tests_run += 6;
        if (if4.dig_en_n !== 4'hF) begin tests_failed++; $display("FAIL reset_dig_en got %b exp 1111", if4.dig_en_n); end
        if (if4.seg_n !== 7'h7F) begin tests_failed++; $display("FAIL reset_seg got %b exp 1111111", if4.seg_n); end
        if (if4.dp_n !== 1'b1) begin tests_failed++; $display("FAIL reset_dp got %b exp 1", if4.dp_n); end
        if (if4.digit_idx !== 2'd0) begin tests_failed++; $display("FAIL reset_idx got %0d exp 0", if4.digit_idx); end
        if (if4.frame_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick got %b exp 0", if4.frame_tick); end
        if (if3.dig_en_n !== 3'h7) begin tests_failed++; $display("FAIL reset_dig3 got %b exp 111", if3.dig_en_n); end
    endtask

    task automatic test_digit_values;
        int first0;
        int last0;
        first0 = -1;
        last0  = -1;
        reset  = 1'b0;
        for (int j = 1; j <= 1024; j++) begin
            @(negedge clk);
            tests_run++;
            if (obs4 !== mod4) begin tests_failed++; $display("FAIL values_model j=%0d got %h exp %h", j, obs4, mod4); end
            if (j == 1) begin
                tests_run++;
                if (if4.frame_tick !== 1'b1) begin tests_failed++; $display("FAIL values_first_tick got %b exp 1", if4.frame_tick); end
            end
            if (if4.dig_en_n === 4'b1110) begin
                if (first0 < 0) first0 = j;
                last0 = j;
                tests_run++;
                if (if4.seg_n !== 7'b1111001 || if4.dp_n !== 1'b1) begin
                    tests_failed++; $display("FAIL values_d0 j=%0d got %b/%b exp 1111001/1", j, if4.seg_n, if4.dp_n);
                end
            end
            if (if4.dig_en_n === 4'b1011) begin
                tests_run++;
                if (if4.seg_n !== 7'b0000000 || if4.dp_n !== 1'b0) begin
                    tests_failed++; $display("FAIL values_d2 j=%0d got %b/%b exp 0000000/0", j, if4.seg_n, if4.dp_n);
                end
            end
            if (if4.dig_en_n === 4'b0111) begin
                tests_run++;
                if (if4.seg_n !== 7'b0001110) begin
                    tests_failed++; $display("FAIL values_d3 j=%0d got %b exp 0001110", j, if4.seg_n);
                end
            end
        end
        tests_run += 2;
        if (first0 != 5) begin tests_failed++; $display("FAIL values_d0_first got %0d exp 5", first0); end
        if (last0 != 256) begin tests_failed++; $display("FAIL values_d0_last got %0d exp 256", last0); end
    endtask

    task automatic test_dead_time;
        int         gap;
        logic [3:0] last_sel;
        gap      = 0;
        last_sel = 4'hF;
        for (int j = 0; j < 2048; j++) begin
            @(negedge clk);
            tests_run += 2;
            if (obs4 !== mod4) begin tests_failed++; $display("FAIL dead_model j=%0d got %h exp %h", j, obs4, mod4); end
            if ($countones(~if4.dig_en_n) > 1) begin tests_failed++; $display("FAIL dead_overlap j=%0d got %b exp one-cold", j, if4.dig_en_n); end
            if (if4.dig_en_n === 4'hF) begin
                gap++;
            end else begin
                if (last_sel !== 4'hF && if4.dig_en_n !== last_sel) begin
                    tests_run++;
                    if (gap != BLANK) begin tests_failed++; $display("FAIL dead_gap j=%0d got %0d exp %0d", j, gap, BLANK); end
                end
                last_sel = if4.dig_en_n;
                gap      = 0;
            end
        end
    endtask

    task automatic test_mid_frame_change;
        logic [15:0] old_v;
        logic [15:0] new_v;
        int          n;
        int          j;
        old_v       = 16'($urandom);
        new_v       = ~old_v;
        if4.digits  = old_v;
        if4.blank   = 4'b0000;
        if4.bright  = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (if4.frame_tick !== 1'b1 && n < 2100);
        tests_run++;
        if (if4.frame_tick !== 1'b1) begin tests_failed++; $display("FAIL mid_tick_wait got %b exp 1", if4.frame_tick); end
        j = 0;
        do begin
            @(negedge clk);
            j++;
            if (j == 300) if4.digits = new_v;
            tests_run++;
            if (obs4 !== mod4) begin tests_failed++; $display("FAIL mid_model j=%0d got %h exp %h", j, obs4, mod4); end
            if (if4.dig_en_n !== 4'hF) begin
                tests_run++;
                if (if4.seg_n !== seg_tab[(old_v >> (4 * if4.digit_idx)) & 16'hF]) begin
                    tests_failed++; $display("FAIL mid_old j=%0d got %b exp %b", j, if4.seg_n, seg_tab[(old_v >> (4 * if4.digit_idx)) & 16'hF]);
                end
            end
        end while (if4.frame_tick !== 1'b1 && j < 2100);
        tests_run++;
        if (j != 1024) begin tests_failed++; $display("FAIL mid_period got %0d exp 1024", j); end
        for (int k = 0; k < 1024; k++) begin
            if (k > 0) @(negedge clk);
            tests_run++;
            if (obs4 !== mod4) begin tests_failed++; $display("FAIL mid_model_new k=%0d got %h exp %h", k, obs4, mod4); end
            if (if4.dig_en_n !== 4'hF) begin
                tests_run++;
                if (if4.seg_n !== seg_tab[(new_v >> (4 * if4.digit_idx)) & 16'hF]) begin
                    tests_failed++; $display("FAIL mid_new k=%0d got %b exp %b", k, if4.seg_n, seg_tab[(new_v >> (4 * if4.digit_idx)) & 16'hF]);
                end
            end
        end
    endtask

    task automatic test_bright_blank;
        int lit_cnt [4];
        int idx_cnt [4];
        int n;
        for (int i = 0; i < 4; i++) begin lit_cnt[i] = 0; idx_cnt[i] = 0; end
        if4.bright = 4'd3;
        if4.blank  = 4'b0010;
        if4.digits = 16'($urandom);
        if4.dp     = 4'($urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (if4.frame_tick !== 1'b1 && n < 2100);
        tests_run++;
        if (if4.frame_tick !== 1'b1) begin tests_failed++; $display("FAIL bright_tick_wait got %b exp 1", if4.frame_tick); end
        for (int k = 0; k < 1024; k++) begin
            if (k > 0) @(negedge clk);
            tests_run++;
            if (obs4 !== mod4) begin tests_failed++; $display("FAIL bright_model k=%0d got %h exp %h", k, obs4, mod4); end
            idx_cnt[if4.digit_idx]++;
            if (if4.dig_en_n !== 4'hF) lit_cnt[if4.digit_idx]++;
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (lit_cnt[i] != ((i == 1) ? 0 : 60)) begin
                tests_failed++; $display("FAIL bright_lit d=%0d got %0d exp %0d", i, lit_cnt[i], (i == 1) ? 0 : 60);
            end
        end
        tests_run++;
        if (idx_cnt[1] != 256) begin tests_failed++; $display("FAIL bright_idx1 got %0d exp 256", idx_cnt[1]); end
    endtask

    task automatic test_reset_mid_scan;
        int n;
        if4.bright = 4'hF;
        if4.blank  = 4'b0000;
        n = 0;
        do begin @(negedge clk); n++; end while (if4.frame_tick !== 1'b1 && n < 2100);
        tests_run++;
        if (if4.frame_tick !== 1'b1) begin tests_failed++; $display("FAIL rst_tick_wait got %b exp 1", if4.frame_tick); end
        for (int k = 0; k < 611; k++) begin
            @(negedge clk);
            tests_run++;
            if (obs4 !== mod4) begin tests_failed++; $display("FAIL rst_model k=%0d got %h exp %h", k, obs4, mod4); end
        end
        tests_run++;
        if (if4.digit_idx !== 2'd2) begin tests_failed++; $display("FAIL rst_pre_idx got %0d exp 2", if4.digit_idx); end
        reset = 1'b1;
        @(negedge clk);
        tests_run += 3;
        if (if4.dig_en_n !== 4'hF || if4.seg_n !== 7'h7F || if4.dp_n !== 1'b1) begin
            tests_failed++; $display("FAIL rst_pins got %b/%b/%b exp 1111/1111111/1", if4.dig_en_n, if4.seg_n, if4.dp_n);
        end
        if (if4.digit_idx !== 2'd0) begin tests_failed++; $display("FAIL rst_idx got %0d exp 0", if4.digit_idx); end
        if (if4.frame_tick !== 1'b0) begin tests_failed++; $display("FAIL rst_tick got %b exp 0", if4.frame_tick); end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if4.frame_tick !== 1'b1 || if4.digit_idx !== 2'd0) begin
            tests_failed++; $display("FAIL rst_resume got tick=%b idx=%0d exp tick=1 idx=0", if4.frame_tick, if4.digit_idx);
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            tests_run++;
            if (obs4 !== mod4) begin tests_failed++; $display("FAIL rst_after_model k=%0d got %h exp %h", k, obs4, mod4); end
        end
    endtask

    task automatic test_three_digits;
        int         n;
        int         last_tick;
        logic [1:0] prev_idx;
        if3.digits = 12'($urandom);
        if3.dp     = 3'($urandom);
        if3.blank  = 3'b000;
        if3.bright = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (if3.frame_tick !== 1'b1 && n < 2100);
        tests_run++;
        if (if3.frame_tick !== 1'b1) begin tests_failed++; $display("FAIL three_tick_wait got %b exp 1", if3.frame_tick); end
        last_tick = 0;
        prev_idx  = if3.digit_idx;
        for (int k = 0; k < 1600; k++) begin
            if (k > 0) @(negedge clk);
            tests_run += 2;
            if (obs3 !== mod3) begin tests_failed++; $display("FAIL three_model k=%0d got %h exp %h", k, obs3, mod3); end
            if (if3.digit_idx === 2'd3) begin tests_failed++; $display("FAIL three_idx_range k=%0d got 3 exp 0..2", k); end
            if (if3.digit_idx !== prev_idx) begin
                tests_run++;
                if (int'(if3.digit_idx) != (int'(prev_idx) + 1) % 3) begin
                    tests_failed++; $display("FAIL three_seq k=%0d got %0d exp %0d", k, if3.digit_idx, (int'(prev_idx) + 1) % 3);
                end
                prev_idx = if3.digit_idx;
            end
            if (k > 0 && if3.frame_tick === 1'b1) begin
                tests_run++;
                if (k - last_tick != 768) begin tests_failed++; $display("FAIL three_period got %0d exp 768", k - last_tick); end
                last_tick = k;
            end
        end
    endtask

    task automatic test_random_frames;
        int chg;
        chg = $urandom_range(50, 700);
        for (int j = 0; j < 5 * 1024; j++) begin
            @(negedge clk);
            tests_run += 2;
            if (obs4 !== mod4) begin tests_failed++; $display("FAIL rand_model4 j=%0d got %h exp %h", j, obs4, mod4); end
            if (obs3 !== mod3) begin tests_failed++; $display("FAIL rand_model3 j=%0d got %h exp %h", j, obs3, mod3); end
            if (j == chg) begin
                if4.digits = 16'($urandom);
                if4.dp     = 4'($urandom);
                if4.blank  = 4'($urandom);
                if4.bright = 4'($urandom_range(0, 15));
                if3.digits = 12'($urandom);
                if3.dp     = 3'($urandom);
                if3.blank  = 3'($urandom);
                if3.bright = 4'($urandom_range(0, 15));
                chg += $urandom_range(300, 1500);
            end
        end
    endtask

    initial begin
        test_reset();
        test_digit_values();
        test_dead_time();
        test_mid_frame_change();
        test_bright_blank();
        test_reset_mid_scan();
        test_three_digits();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seven_seg_scan_n.md
# seven_seg_scan_n

Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display. It scans `NUM_DIGITS` hex digits with per-digit blanking and decimal points, global PWM brightness, and a dead-time between digit switches to prevent ghosting. Inputs are captured once per frame into a shadow register, so the displayed value never tears mid-scan. It sits between the application's display value registers and the board's segment and digit-select pins, and replaces the fixed two-digit scanner.

## Interface
- `NUM_DIGITS`, default 2: number of digits scanned; legal range 2..8.
- `DIV_BITS`, default 16: dwell per digit is 2^DIV_BITS clk cycles; must be ≥ 8.
- `BLANK_CYCLES`, default 64: dead-time at the start of each dwell; must be < 2^(DIV_BITS-4).
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous reset, active-high.
- `digits`  in  4*NUM_DIGITS: hex nibbles; digit k occupies `[4k+3:4k]`.
- `dp`  in  NUM_DIGITS: decimal point request per digit, active-high.
- `blank`  in  NUM_DIGITS: forces digit k dark (segments and dp off), active-high.
- `bright`  in  4: brightness level; 15 is full, 0 is 1/16 duty.
- `dig_en_n`  out  NUM_DIGITS: digit select, one-cold, active-low.
- `seg_n`  out  7: segments, active-low; `[6:0]` = g f e d c b a.
- `dp_n`  out  1: decimal point, active-low.
- `digit_idx`  out  max(1,$clog2(NUM_DIGITS)): index of the digit currently being scanned.
- `frame_tick`  out  1: one-cycle pulse at the start of each frame.

## Operation
- State: dwell counter `cnt` (DIV_BITS wide), digit index `idx`, shadow registers for `digits`, `dp`, `blank` and `bright`.
- `cnt` increments every cycle and wraps from 2^DIV_BITS-1 to 0.
- On `cnt` wrap, `idx` advances by 1. It wraps from NUM_DIGITS-1 to 0, and never reaches NUM_DIGITS when NUM_DIGITS is not a power of 2.
- Shadow load: the shadow registers capture all inputs in every cycle where `cnt`==0 and `idx`==0, including the first cycle after reset. Input changes at any other time have no effect until the next frame.
- The digit is lit when all of the following hold:
  - `cnt` ≥ BLANK_CYCLES;
  - `cnt[DIV_BITS-1:DIV_BITS-4]` ≤ shadow `bright`;
  - shadow `blank[idx]` is 0.
- While lit:
  - `dig_en_n` has only bit `idx` low;
  - `seg_n` holds the hex decode of shadow nibble `idx`;
  - `dp_n` is the inverse of shadow `dp[idx]`.
- While not lit: `dig_en_n`, `seg_n` and `dp_n` are all ones.
- Hex decode (`seg_n`, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- `frame_tick` is high for exactly one cycle when `idx` is 0 and `cnt` is 0, i.e. the shadow-load cycle, as seen at the outputs.

## Timing
- All outputs are registered. Outputs in cycle t+1 reflect `cnt`, `idx` and shadow contents in cycle t.
- Shadow-load latency: an input applied at a frame start drives the pins 1 cycle later, once the digit is lit.
- Dwell per digit is 2^DIV_BITS cycles. A frame is NUM_DIGITS·2^DIV_BITS cycles.
- Dead-time: `dig_en_n` is all ones for BLANK_CYCLES cycles between any two digit selections. Two digits are never selected in the same cycle.
- Reset values, taking effect the cycle after `reset` is sampled high:
  - `cnt`=0, `idx`=0;
  - `dig_en_n`, `seg_n`, `dp_n` all ones;
  - `digit_idx`=0, `frame_tick`=0;
  - shadow `digits`=0, shadow `blank`=all ones, shadow `dp`=0, shadow `bright`=0.
- Reset asserted mid-scan aborts the dwell immediately. The scan restarts at digit 0, and a frame load occurs on the first cycle with `reset` low.
- `bright`=15 gives full duty minus dead-time. With `bright`=0, only cycles up to 2^(DIV_BITS-4)-1 qualify, after the dead-time.

## Test plan
Benches use NUM_DIGITS=4, DIV_BITS=8, BLANK_CYCLES=4, `bright`=15 unless noted.
1. Reset, then `digits`=16'hF821, `blank`=0, `dp`=4'b0100:
   - digit 0 lit on cycles 5..256 relative to the load, with `seg_n`=1111001 and `dig_en_n`=1110;
   - digit 2 shows `seg_n`=0000000 with `dp_n`=0;
   - digit 3 shows `seg_n`=0001110.
2. Dead-time: monitor `dig_en_n` every cycle → never two bits low at once; exactly 4 all-ones cycles at each digit boundary when `bright`=15.
3. Change `digits` mid-frame, 300 cycles after a `frame_tick` → pins unchanged until the next `frame_tick`, then the new values appear; `frame_tick` period is exactly 1024 cycles.
4. `bright`=3 → each dwell is lit only while `cnt` is in 4..63, giving 60 lit cycles per 256. `blank`=4'b0010 → digit 1 stays fully dark while its `digit_idx`=1 still reports.
5. Assert `reset` for 1 cycle while `idx`=2 and `cnt`=100 → next cycle all outputs are at reset values; scan resumes at digit 0 and a `frame_tick` occurs after release.
6. NUM_DIGITS=3 → `digit_idx` sequence is 0,1,2,0 and never reaches 3; `frame_tick` period is 768 cycles.
